cam_ctrl: RTL and testbench

Request sequencer for the 32-entry, 32-bit CAM. Accepts lookup and insert requests over a valid/ready handshake and runs each as a fixed search/write sequence on the CAM ports. Tracks slot occupancy and allocates free slots for inserts, so duplicate keys are never written twice. Sits between the client logic and the CAM, and is the only driver of the CAM's write and search ports.

---
 rtl/cam_ctrl_if.sv | 26 ++
 rtl/cam_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cam_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_ctrl_if.sv
// Client-side request/response channel of cam_ctrl.
// Member names keep the controller's point of view: _i into cam_ctrl, _o out of it.
interface cam_ctrl_if #(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned IDX_W = 5
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_op_i;
  logic [KEY_W-1:0] req_key_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_hit_o;
  logic [IDX_W-1:0] rsp_index_o;
  logic             rsp_err_o;

  modport master (
    output req_valid_i, req_op_i, req_key_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_key_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_err_o
  );
endinterface

// File: rtl/cam_ctrl.sv
// Lookup/insert sequencer for a 32-entry CAM with slot allocation and occupancy tracking.
// Define CAM_CTRL_EVICT_EN to overwrite a round-robin victim slot on insert-when-full.
module cam_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned KEY_W = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cam_ctrl_if.slave        bus,
  output logic [IDX_W:0]   occupancy_o,
  output logic             cam_write_enable_o,
  output logic [IDX_W-1:0] cam_write_index_o,
  output logic [KEY_W-1:0] cam_write_data_o,
  output logic             cam_search_enable_o,
  output logic [KEY_W-1:0] cam_search_data_o,
  input  logic [IDX_W-1:0] cam_search_index_i,
  input  logic             cam_search_valid_i
);

  typedef enum logic [1:0] {StIdle, StSearch, StWrite, StResp} state_e;

  state_e           r_state, w_state_next;
  logic             r_op;
  logic [KEY_W-1:0] r_key;
  logic [DEPTH-1:0] r_bitmap;
  logic [IDX_W:0]   r_occ;
  logic             r_hit;
  logic             r_err;
  logic [IDX_W-1:0] r_index;
  logic             w_ready;
  logic             w_accept;
  logic             w_full;
  logic [IDX_W-1:0] w_free_idx;

`ifdef CAM_CTRL_EVICT_EN
  logic [IDX_W-1:0] r_victim;
`endif

  assign w_ready  = (r_state == StIdle) && !rst_i;
  assign w_accept = w_ready && bus.req_valid_i;
  assign w_full   = (r_occ == (IDX_W + 1)'(DEPTH));

  // Lowest clear bit of the bitmap; scanning downwards lets the lowest index win.
  always_comb begin
    w_free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!r_bitmap[i]) w_free_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = StSearch;
      StSearch: begin
        if (cam_search_valid_i || !r_op) begin
          w_state_next = StResp;
        end else if (!w_full) begin
          w_state_next = StWrite;
        end else begin
`ifdef CAM_CTRL_EVICT_EN
          w_state_next = StWrite;
`else
          w_state_next = StResp;
`endif
        end
      end
      StWrite:  w_state_next = StResp;
      StResp:   if (bus.rsp_ready_i) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Strobes are gated by rst_i so a reset landing on WRITE never reaches the CAM.
  always_comb begin
    bus.req_ready_o     = w_ready;
    bus.rsp_valid_o     = 1'b0;
    cam_write_enable_o  = 1'b0;
    cam_write_index_o   = '0;
    cam_write_data_o    = '0;
    cam_search_enable_o = 1'b0;
    cam_search_data_o   = '0;
    if (!rst_i) begin
      unique case (r_state)
        StSearch: begin
          cam_search_enable_o = 1'b1;
          cam_search_data_o   = r_key;
        end
        StWrite: begin
          cam_write_enable_o = 1'b1;
          cam_write_index_o  = r_index;
          cam_write_data_o   = r_key;
        end
        StResp:  bus.rsp_valid_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rsp_hit_o   = r_hit;
  assign bus.rsp_index_o = r_index;
  assign bus.rsp_err_o   = r_err;
  assign occupancy_o     = r_occ;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op     <= 1'b0;
      r_key    <= '0;
      r_bitmap <= '0;
      r_occ    <= '0;
      r_hit    <= 1'b0;
      r_err    <= 1'b0;
      r_index  <= '0;
`ifdef CAM_CTRL_EVICT_EN
      r_victim <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op    <= bus.req_op_i;
            r_key   <= bus.req_key_i;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
            r_index <= '0;
          end
        end
        StSearch: begin
          if (cam_search_valid_i) begin
            r_hit   <= 1'b1;
            r_index <= cam_search_index_i;
          end else if (r_op) begin
`ifdef CAM_CTRL_EVICT_EN
            r_index <= w_full ? r_victim : w_free_idx;
`else
            if (w_full) r_err   <= 1'b1;
            else        r_index <= w_free_idx;
`endif
          end
        end
        StWrite: begin
          r_bitmap[r_index] <= 1'b1;
          if (!r_bitmap[r_index]) begin
            r_occ <= r_occ + 1'b1;
          end
`ifdef CAM_CTRL_EVICT_EN
          else begin
            r_victim <= r_victim + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Randomized bench for cam_ctrl: behavioural CAM plus a slot/occupancy reference model.
// Honours CAM_CTRL_EVICT_EN in the model so either build can be checked.
module tb_cam_ctrl;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned KEY_W = 32;
  localparam int unsigned IDX_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_ctrl_if #(.KEY_W(KEY_W), .IDX_W(IDX_W)) bus ();

  logic [IDX_W:0]   occ;
  logic             we;
  logic [IDX_W-1:0] wi;
  logic [KEY_W-1:0] wd;
  logic             se;
  logic [KEY_W-1:0] sd;
  logic [IDX_W-1:0] si;
  logic             sv;

  cam_ctrl #(.DEPTH(DEPTH), .KEY_W(KEY_W), .IDX_W(IDX_W)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .bus                 (bus),
    .occupancy_o         (occ),
    .cam_write_enable_o  (we),
    .cam_write_index_o   (wi),
    .cam_write_data_o    (wd),
    .cam_search_enable_o (se),
    .cam_search_data_o   (sd),
    .cam_search_index_i  (si),
    .cam_search_valid_i  (sv)
  );

  // Behavioural CAM: combinational match, lowest row wins, cleared by reset.
  logic [KEY_W-1:0] cam_mem [DEPTH];
  logic [DEPTH-1:0] cam_vld;

  always_comb begin
    sv = 1'b0;
    si = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (cam_vld[i] && (cam_mem[i] == sd)) begin
        sv = 1'b1;
        si = IDX_W'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cam_vld <= '0;
    end else if (we) begin
      cam_vld[wi] <= 1'b1;
      cam_mem[wi] <= wd;
    end
  end

  int               wr_cnt = 0;
  logic [IDX_W-1:0] last_wi;
  logic [KEY_W-1:0] last_wd;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_cnt  <= wr_cnt + 1;
      last_wi <= wi;
      last_wd <= wd;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: slots fill in order, so slots 0..m_occ-1 are the occupied ones.
  logic [KEY_W-1:0] m_key [DEPTH];
  int               m_occ;
  int               m_victim;

  task automatic model_reset();
    m_occ    = 0;
    m_victim = 0;
  endtask

  task automatic model_req(input bit op, input logic [KEY_W-1:0] key, output bit hit,
                           output int idx, output bit err, output bit wr);
    hit = 0;
    idx = 0;
    err = 0;
    wr  = 0;
    for (int i = 0; i < m_occ; i++) begin
      if (!hit && m_key[i] == key) begin
        hit = 1;
        idx = i;
      end
    end
    if (!hit && op) begin
      if (m_occ < int'(DEPTH)) begin
        idx          = m_occ;
        m_key[m_occ] = key;
        m_occ++;
        wr           = 1;
      end else begin
`ifdef CAM_CTRL_EVICT_EN
        idx             = m_victim;
        m_key[m_victim] = key;
        m_victim        = (m_victim + 1) % int'(DEPTH);
        wr              = 1;
`else
        err = 1;
`endif
      end
    end
  endtask

  task automatic do_req(input bit op, input logic [KEY_W-1:0] key, input int stall);
    bit e_hit, e_err, e_wr, got;
    int e_idx, wr0, lat;
    model_req(op, key, e_hit, e_idx, e_err, e_wr);
    @(negedge clk);
    check("ready_idle", bus.req_ready_o, 1);
    wr0             = wr_cnt;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_key_i   = key;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_key_i   = $urandom();
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("search_en", se, 1);
        check("search_key", sd, key);
        check("ready_busy", bus.req_ready_o, 0);
      end
      if (lat == 2) check("write_strobe", we, e_wr);
      if (bus.rsp_valid_o === 1'b1) got = 1;
    end
    check("rsp_latency", lat, e_wr ? 3 : 2);
    if (got) begin
      check("rsp_hit", bus.rsp_hit_o, e_hit);
      check("rsp_index", bus.rsp_index_o, e_idx);
      check("rsp_err", bus.rsp_err_o, e_err);
      check("occupancy", occ, m_occ);
      check("ready_in_rsp", bus.req_ready_o, 0);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", bus.rsp_valid_o, 1);
        check("stall_hit", bus.rsp_hit_o, e_hit);
        check("stall_index", bus.rsp_index_o, e_idx);
        check("stall_err", bus.rsp_err_o, e_err);
        check("stall_ready", bus.req_ready_o, 0);
      end
      bus.rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready_i = 1'b0;
      @(negedge clk);
      check("idle_after_rsp", bus.req_ready_o, 1);
      check("rsp_cleared", bus.rsp_valid_o, 0);
    end
    check("write_count", wr_cnt - wr0, e_wr);
    if (e_wr) begin
      check("write_idx", last_wi, e_idx);
      check("write_data", last_wd, key);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KEY_W-1:0] k;
    int wr0;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 1'b0;
    bus.req_key_i   = '0;
    bus.rsp_ready_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", bus.req_ready_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_hit", bus.rsp_hit_o, 0);
    check("rst_err", bus.rsp_err_o, 0);
    check("rst_index", bus.rsp_index_o, 0);
    check("rst_occ", occ, 0);
    check("rst_we", we, 0);
    check("rst_se", se, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_req(1'b0, 32'hDEADBEEF, 0);
    do_req(1'b1, 32'h12345678, 0);
    do_req(1'b0, 32'h12345678, 0);
    do_req(1'b1, 32'h12345678, 0);
    do_req(1'b0, 32'hCAFEF00D, 10);
    for (int i = 1; i <= 33; i++) do_req(1'b1, 32'hA000_0000 + i, 0);

    repeat (80) begin
      k = ($urandom_range(0, 3) == 0) ? $urandom() : 32'hA000_0000 + $urandom_range(0, 40);
      do_req(1'($urandom_range(0, 1)), k, $urandom_range(0, 2));
    end

    // Reset landing on the WRITE cycle of an insert into an empty CAM.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst2_occ", occ, 0);
    wr0             = wr_cnt;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 1'b1;
    bus.req_key_i   = 32'h5A5A_0001;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("wrst_we", we, 0);
    check("wrst_ready", bus.req_ready_o, 0);
    check("wrst_rsp_valid", bus.rsp_valid_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("wrst_idle", bus.req_ready_o, 1);
    check("wrst_occ", occ, 0);
    check("wrst_rsp_dropped", bus.rsp_valid_o, 0);
    check("wrst_no_write", wr_cnt - wr0, 0);
    do_req(1'b0, 32'h5A5A_0001, 0);
    do_req(1'b1, 32'h5A5A_0001, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
